// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
//   mem_state_t : responder FSM states
//   LFSR_SEED   : reset value of the wait-state LFSR (never all-zero)
//   LFSR_TAPS   : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   lfsr_step   : one Fibonacci shift; feedback enters at bit 0
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RDPEND
  } mem_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM with a registered read port, write-first.
//   clk   : clock
//   en    : access enable (read or write this edge)
//   we    : 1 = write wdata to addr; the read register also takes wdata
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, changes only on enabled edges
module mem_responder_ram
  import mem_pkg::*;
#(
  parameter int    ADDR_W    = 12,
  parameter int    DATA_W    = 16,
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata_reg <= wdata;
      end else begin
        rdata_reg <= mem[addr];
      end
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU wait/rddatavalid bus.
// Inserts fixed (plus optional pseudo-random) wait states before accepting a
// request, then returns read data READ_LATENCY cycles after the accept edge.
//   clk, rst       : clock, asynchronous active-high reset
//   i_addr         : word address, sampled on the accept edge
//   i_rd / i_wr    : requests, held by the master until accepted (wr wins)
//   i_wrdata       : write data, sampled on the accept edge
//   o_waitrequest  : 1 = request not accepted this cycle (registered decode)
//   o_rddata       : read data, holds its last value between pulses
//   o_rddatavalid  : one-cycle pulse qualifying o_rddata
module mem_responder
  import mem_pkg::*;
#(
  parameter int    ADDR_W       = 16,
  parameter int    DATA_W       = 16,
  parameter int    DEPTH        = 4096,
  parameter int    WAIT_CYCLES  = 1,
  parameter int    READ_LATENCY = 1,
  parameter int    RAND_WAIT    = 0,
  parameter string INIT_FILE    = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rd,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wrdata,
  output logic              o_waitrequest,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rddatavalid
);

  localparam int          RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U   = DEPTH;
  localparam logic [4:0]  WAIT_INIT = 5'(WAIT_CYCLES);
  localparam logic [2:0]  RLAT_INIT = 3'(READ_LATENCY - 1);

  mem_state_t        state_reg, state_next;
  logic [4:0]        wcnt_reg, wcnt_next;
  logic [2:0]        rlat_reg, rlat_next;
  logic [15:0]       lfsr_reg;
  logic [DATA_W-1:0] last_reg;
  logic              rd_oor_reg;
  logic              ram_valid_reg;

  logic              req;
  logic              accept;
  logic              in_range;
  logic [4:0]        wait_load;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_valid;

  assign req      = i_rd | i_wr;
  assign accept   = req && (state_reg == S_WAIT) && (wcnt_reg == 5'd0);
  assign in_range = (32'(i_addr) < DEPTH_U);
  assign wait_load = WAIT_INIT + ((RAND_WAIT != 0) ? {3'b000, lfsr_reg[1:0]} : 5'd0);

  // Out-of-range accesses never touch the RAM; reads of them return zero.
  mem_responder_ram #(
    .ADDR_W    (RAM_AW),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (accept && in_range),
    .we    (i_wr),
    .addr  (i_addr[RAM_AW-1:0]),
    .wdata (i_wrdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      wcnt_reg      <= '0;
      rlat_reg      <= '0;
      lfsr_reg      <= LFSR_SEED;
      last_reg      <= '0;
      rd_oor_reg    <= 1'b0;
      ram_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wcnt_reg      <= wcnt_next;
      rlat_reg      <= rlat_next;
      lfsr_reg      <= lfsr_step(lfsr_reg);
      ram_valid_reg <= accept && i_rd && !i_wr;
      if (accept) rd_oor_reg <= !in_range;
      if (o_rddatavalid) last_reg <= pipe_data;
    end
  end

  assign ram_q = rd_oor_reg ? '0 : ram_rdata;

  // Extra READ_LATENCY-1 stages after the RAM's own registered read.
  if (READ_LATENCY > 1) begin : g_dly
    logic [DATA_W-1:0] dly_data_reg  [READ_LATENCY-1];
    logic              dly_valid_reg [READ_LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
          dly_data_reg[i]  <= '0;
          dly_valid_reg[i] <= 1'b0;
        end
      end else begin
        dly_data_reg[0]  <= ram_q;
        dly_valid_reg[0] <= ram_valid_reg;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          dly_data_reg[i]  <= dly_data_reg[i-1];
          dly_valid_reg[i] <= dly_valid_reg[i-1];
        end
      end
    end

    assign pipe_data  = dly_data_reg[READ_LATENCY-2];
    assign pipe_valid = dly_valid_reg[READ_LATENCY-2];
  end else begin : g_nodly
    assign pipe_data  = ram_q;
    assign pipe_valid = ram_valid_reg;
  end

  always_comb begin
    state_next    = state_reg;
    wcnt_next     = wcnt_reg;
    rlat_next     = rlat_reg;
    o_waitrequest = !((state_reg == S_WAIT) && (wcnt_reg == 5'd0));
    o_rddatavalid = (state_reg == S_RDPEND) && (rlat_reg == 3'd0) && pipe_valid;
    case (state_reg)
      S_IDLE: begin
        if (req) begin
          wcnt_next  = wait_load;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_next = S_IDLE;           // master withdrew: abort silently
        end else if (wcnt_reg != 5'd0) begin
          wcnt_next = wcnt_reg - 5'd1;
        end else if (i_wr) begin
          state_next = S_IDLE;           // write (wins over a simultaneous read)
        end else begin
          rlat_next  = RLAT_INIT;
          state_next = S_RDPEND;
        end
      end
      S_RDPEND: begin
        if (rlat_reg == 3'd0) state_next = S_IDLE;
        else                  rlat_next  = rlat_reg - 3'd1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign o_rddata = o_rddatavalid ? pipe_data : last_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. Three instances:
//   dut0 WAIT=1 LAT=1, dut1 WAIT=0 LAT=3, dut2 WAIT=1 LAT=2 RAND_WAIT=1.
// Expected read data is queued when a read is accepted and compared when
// o_rddatavalid arrives.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        rd_s      [3];
  logic        wr_s      [3];
  logic        waitreq_s [3];
  logic        rdv_s     [3];
  logic [15:0] addr_s    [3];
  logic [15:0] wrdata_s  [3];
  logic [15:0] rddata_s  [3];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rdv_cnt      [3];
  int rdv_cyc      [3];
  int reads_issued [3];
  logic [15:0] exp_q [3][$];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    mem_responder #(
      .ADDR_W       (16),
      .DATA_W       (16),
      .DEPTH        (4096),
      .WAIT_CYCLES  ((gi == 1) ? 0 : 1),
      .READ_LATENCY ((gi == 0) ? 1 : ((gi == 1) ? 3 : 2)),
      .RAND_WAIT    ((gi == 2) ? 1 : 0),
      .INIT_FILE    ("")
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .i_addr        (addr_s[gi]),
      .i_rd          (rd_s[gi]),
      .i_wr          (wr_s[gi]),
      .i_wrdata      (wrdata_s[gi]),
      .o_waitrequest (waitreq_s[gi]),
      .o_rddata      (rddata_s[gi]),
      .o_rddatavalid (rdv_s[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, score any read data.
  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (rdv_s[d]) begin
        rdv_cnt[d]++;
        rdv_cyc[d] = cyc;
        if (exp_q[d].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rddatavalid dut%0d: actual data=%h required no pulse", d, rddata_s[d]);
        end else begin
          e = exp_q[d].pop_front();
          check($sformatf("rddata_dut%0d", d), int'(rddata_s[d]), int'(e));
        end
      end
    end
  endtask

  // Hold a request until accepted; c = cycles from request to accept cycle.
  task automatic do_op(input int d, input bit r, input bit w, input logic [15:0] a,
                       input logic [15:0] wd, input bit exp_valid, input logic [15:0] exp_data,
                       output int c, output int acc);
    addr_s[d]   = a;
    wrdata_s[d] = wd;
    rd_s[d]     = r;
    wr_s[d]     = w;
    c = 0;
    while (waitreq_s[d] && c < 64) begin
      tick();
      c++;
    end
    acc = cyc;
    if (waitreq_s[d]) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout dut%0d: actual waitrequest=1 required 0 within 64 cycles", d);
    end else if (exp_valid) begin
      exp_q[d].push_back(exp_data);
      reads_issued[d]++;
    end
    $display("dut%0d rd=%0b wr=%0b addr=%h wdata=%h accepted after %0d cycles", d, r, w, a, wd, c);
    tick();
    rd_s[d] = 1'b0;
    wr_s[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (exp_q[d].size() != 0 && n < 64) begin
      tick();
      n++;
    end
    if (exp_q[d].size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rddatavalid_timeout dut%0d: actual %0d reads outstanding required 0", d, exp_q[d].size());
      exp_q[d].delete();
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int c, acc, c0, base, n, op, ai;
    bit r, w;
    logic [15:0] wd, ev;
    logic [15:0] mdl [8];

    vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF};
    vecs[2] = '{1'b0, 1'b1, 16'h0000, 16'h1111, 1'b0, 16'h0000};
    vecs[3] = '{1'b0, 1'b1, 16'h1000, 16'h5555, 1'b0, 16'h0000};
    vecs[4] = '{1'b1, 1'b0, 16'h1000, 16'h0000, 1'b1, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1111};
    vecs[6] = '{1'b1, 1'b1, 16'h0007, 16'h00AA, 1'b0, 16'h0000};
    vecs[7] = '{1'b1, 1'b0, 16'h0007, 16'h0000, 1'b1, 16'h00AA};
    vecs[8] = '{1'b0, 1'b1, 16'h0FFF, 16'h7777, 1'b0, 16'h0000};
    vecs[9] = '{1'b1, 1'b0, 16'h0FFF, 16'h0000, 1'b1, 16'h7777};

    for (int d = 0; d < 3; d++) begin
      rd_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = '0; wrdata_s[d] = '0;
      rdv_cnt[d] = 0; rdv_cyc[d] = 0; reads_issued[d] = 0;
    end

    // Reset state
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_waitrequest_dut%0d", d), int'(waitreq_s[d]), 1);
      check($sformatf("reset_rddatavalid_dut%0d", d), int'(rdv_s[d]), 0);
      check($sformatf("reset_rddata_dut%0d", d), int'(rddata_s[d]), 0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed table on dut0: basic write/read, out-of-range, rd&wr together
    for (int i = 0; i < 10; i++) begin
      do_op(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
            vecs[i].exp_valid, vecs[i].exp_data, c, acc);
      check($sformatf("vec%0d_accept_cycle", i), c, 2);
      if (vecs[i].exp_valid) begin
        wait_idle(0);
        check($sformatf("vec%0d_read_latency", i), rdv_cyc[0] - acc, 1);
        tick();
      end
    end

    // CPU fetch pattern on dut0: rd held continuously across 8 words
    for (int i = 0; i < 8; i++) begin
      wd = 16'hA000 + 16'(i * 16'h0111);
      do_op(0, 1'b0, 1'b1, 16'h0100 + 16'(i), wd, 1'b0, 16'h0000, c, acc);
    end
    base = rdv_cnt[0];
    rd_s[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr_s[0] = 16'h0100 + 16'(i);
      n = 0;
      while (waitreq_s[0] && n < 64) begin
        tick();
        n++;
      end
      if (waitreq_s[0]) begin
        n_checks++;
        n_fail++;
        $display("FAIL fetch_accept_timeout word %0d: actual waitrequest=1 required 0", i);
      end else begin
        ev = 16'hA000 + 16'(i * 16'h0111);
        exp_q[0].push_back(ev);
        reads_issued[0]++;
      end
      $display("dut0 fetch addr=%h accepted after %0d cycles", addr_s[0], n);
      tick();
    end
    rd_s[0] = 1'b0;
    wait_idle(0);
    check("fetch_rddatavalid_count", rdv_cnt[0] - base, 8);
    tick();

    // LAT=3, WAIT=0 timing and hold-off during RDPEND on dut1
    do_op(1, 1'b0, 1'b1, 16'h0002, 16'hC0DE, 1'b0, 16'h0000, c, acc);
    do_op(1, 1'b0, 1'b1, 16'h0003, 16'h3333, 1'b0, 16'h0000, c, acc);
    c0 = cyc;
    addr_s[1] = 16'h0002;
    rd_s[1]   = 1'b1;
    check("t3_waitrequest_c0", int'(waitreq_s[1]), 1);
    tick();
    check("t3_waitrequest_c1", int'(waitreq_s[1]), 0);
    exp_q[1].push_back(16'hC0DE);
    reads_issued[1]++;
    tick();
    addr_s[1] = 16'h0003;
    check("t3_waitrequest_c2", int'(waitreq_s[1]), 1);
    tick();
    check("t3_waitrequest_c3", int'(waitreq_s[1]), 1);
    tick();
    check("t3_waitrequest_c4", int'(waitreq_s[1]), 1);
    check("t3_rddatavalid_cycle", rdv_cyc[1] - c0, 4);
    tick();
    check("t3_waitrequest_c5", int'(waitreq_s[1]), 1);
    tick();
    check("t3_waitrequest_c6", int'(waitreq_s[1]), 0);
    exp_q[1].push_back(16'h3333);
    reads_issued[1]++;
    $display("dut1 back-to-back reads 0002/0003 accepted in cycles 1 and 6");
    tick();
    rd_s[1] = 1'b0;
    wait_idle(1);
    check("t3_second_rddatavalid_cycle", rdv_cyc[1] - c0, 9);
    tick();

    // Reset during RDPEND on dut1
    do_op(1, 1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000, c, acc);
    addr_s[1] = 16'h0005;
    rd_s[1]   = 1'b1;
    n = 0;
    while (waitreq_s[1] && n < 64) begin
      tick();
      n++;
    end
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_rdpend_waitrequest", int'(waitreq_s[1]), 1);
    check("rst_rdpend_rddata", int'(rddata_s[1]), 0);
    check("rst_rdpend_rddatavalid", int'(rdv_s[1]), 0);
    rd_s[1] = 1'b0;
    base = rdv_cnt[1];
    $display("dut1 reset asserted during pending read of 0005");
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("rst_no_rddatavalid", rdv_cnt[1] - base, 0);
    do_op(1, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'h1234, c, acc);
    wait_idle(1);
    tick();

    // Random traffic with random wait states on dut2
    for (int i = 0; i < 8; i++) begin
      mdl[i] = 16'($urandom);
      do_op(2, 1'b0, 1'b1, 16'h0020 + 16'(i), mdl[i], 1'b0, 16'h0000, c, acc);
    end
    for (int k = 0; k < 200; k++) begin
      op = int'($urandom_range(0, 2));
      ai = int'($urandom_range(0, 7));
      wd = 16'($urandom);
      r  = (op != 1);
      w  = (op != 0);
      do_op(2, r, w, 16'h0020 + 16'(ai), wd, r && !w, mdl[ai], c, acc);
      if (w) mdl[ai] = wd;
      check($sformatf("rand%0d_wait_in_range", k), int'(c >= 2 && c <= 5), 1);
      if (r && !w) begin
        wait_idle(2);
        tick();
      end
    end

    for (int d = 0; d < 3; d++) begin
      check($sformatf("rddatavalid_count_dut%0d", d), rdv_cnt[d], reads_issued[d]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
